// File: rtl/y86_pkg.sv
// y86_pkg: shared types and helpers for the y86 bus memory slice.
//   mem_state_t    - responder state (LOAD, RELEASE, RUN)
//   WORD_W         - bus word width in bits
//   BYTES_PER_WORD - byte lanes per bus word
//   lane_rot()     - byte lane holding byte idx of a word starting at lane base
package y86_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } mem_state_t;

    // Lane = (base + idx) mod 4; 2-bit arithmetic wraps for free.
    function automatic logic [1:0] lane_rot(input logic [1:0] base, input logic [1:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/y86_mem_bank.sv
// y86_mem_bank: one byte lane of the bus memory.
//   clk   - write clock
//   we    - write enable
//   waddr - write row
//   wdata - write byte
//   raddr - read row (asynchronous read)
//   rdata - read byte
// Contents are never reset.
module y86_mem_bank #(
    parameter int unsigned ROW_W = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ROW_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [ROW_W-1:0] raddr,
    output logic [7:0]       rdata
);

    logic [7:0] mem [0:(1 << ROW_W) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/y86_bus_mem.sv
// y86_bus_mem: byte-addressed memory responder for the y86 sequential core.
// A byte-serial loader fills memory while the core is held in reset; then the
// core gets zero-latency (unaligned, wrapping) word reads and single-edge writes.
//   clk, rst            - clock, async active-high reset
//   bus_A/RE/WE         - core address and strobes
//   bus_wdata/bus_rdata - core write / read data (little-endian)
//   ld_valid/byte/last  - loader stream; ld_ready accepts it (LOAD only)
//   cpu_rst             - reset to the core, high until RUN
//   bus_err             - sticky fault flag (load wrap, out-of-range, RE+WE)
//   rd_count/wr_count   - access statistics, present with Y86_MEM_STATS_EN,
//                         otherwise tied to zero
module y86_bus_mem
    import y86_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] bus_A,
    input  logic              bus_RE,
    input  logic              bus_WE,
    input  logic [WORD_W-1:0] bus_wdata,
    output logic [WORD_W-1:0] bus_rdata,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              cpu_rst,
    output logic              bus_err,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    localparam int unsigned ROW_W = ADDR_W - 2;

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ld_ptr_q;
    logic              err_q, err_set;

    logic [ADDR_W-1:0] a;
    logic [1:0]        off;
    logic [ROW_W-1:0]  row;
    logic              oob, run, rd_ok, wr_ok, ld_xfer;
    logic [WORD_W-1:0] rd_word;

    logic [7:0]        bank_rd  [BYTES_PER_WORD];
    logic [7:0]        bank_wd  [BYTES_PER_WORD];
    logic [ROW_W-1:0]  bank_row [BYTES_PER_WORD];
    logic [ROW_W-1:0]  bank_wa  [BYTES_PER_WORD];
    logic [BYTES_PER_WORD-1:0] bank_we;

    assign a       = bus_A[ADDR_W-1:0];
    assign off     = a[1:0];
    assign row     = a[ADDR_W-1:2];
    assign oob     = |bus_A[WORD_W-1:ADDR_W];
    assign run     = (state_q == ST_RUN);
    assign rd_ok   = run && bus_RE && !oob;
    // rst gating keeps a write strobed in the reset cycle from landing.
    assign wr_ok   = run && bus_WE && !oob && !rst;
    assign ld_xfer = ld_valid && ld_ready && !rst;

    always_comb begin
        state_d  = state_q;
        ld_ready = 1'b0;
        cpu_rst  = 1'b1;
        unique case (state_q)
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_xfer && ld_last) state_d = ST_RELEASE;
            end
            ST_RELEASE: state_d = ST_RUN;
            ST_RUN:     cpu_rst = 1'b0;
            default:    state_d = ST_LOAD;
        endcase
    end

    assign err_set = (ld_xfer && (&ld_ptr_q))
                   || (run && (bus_RE || bus_WE) && oob)
                   || (run && bus_RE && bus_WE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_LOAD;
            ld_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ld_xfer) ld_ptr_q <= ld_ptr_q + 1'b1;
            if (err_set) err_q <= 1'b1;
        end
    end

    assign bus_err = err_q;

    // Lanes below the start offset hold bytes that spilled into the next row;
    // byte i of the word lives in lane (off + i) mod 4.
    always_comb begin
        bank_we = '0;
        rd_word = '0;
        for (int unsigned l = 0; l < BYTES_PER_WORD; l++) begin
            logic [1:0] wsel;
            wsel        = 2'(l) - off;
            bank_row[l] = (2'(l) < off) ? row + ROW_W'(1) : row;
            if (state_q == ST_LOAD) begin
                bank_wa[l] = ld_ptr_q[ADDR_W-1:2];
                bank_wd[l] = ld_byte;
                bank_we[l] = ld_xfer && (ld_ptr_q[1:0] == 2'(l));
            end else begin
                bank_wa[l] = bank_row[l];
                bank_wd[l] = bus_wdata[8*wsel +: 8];
                bank_we[l] = wr_ok;
            end
        end
        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
            rd_word[8*i +: 8] = bank_rd[lane_rot(off, 2'(i))];
        end
    end

    assign bus_rdata = rd_ok ? rd_word : '0;

    for (genvar l = 0; l < BYTES_PER_WORD; l++) begin : g_bank
        y86_mem_bank #(
            .ROW_W(ROW_W)
        ) u_bank (
            .clk  (clk),
            .we   (bank_we[l]),
            .waddr(bank_wa[l]),
            .wdata(bank_wd[l]),
            .raddr(bank_row[l]),
            .rdata(bank_rd[l])
        );
    end

`ifdef Y86_MEM_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_ok && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 1'b1;
            if (wr_ok && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 1'b1;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_y86_bus_mem.sv
// tb_y86_bus_mem: self-checking bench for y86_bus_mem (ADDR_W = 12).
// A byte-array model of memory predicts every read; expected read words are
// queued when the read is driven and compared when the DUT output settles.
module tb_y86_bus_mem;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned MSIZE  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_A;
    logic        bus_RE, bus_WE;
    logic [31:0] bus_wdata, bus_rdata;
    logic        ld_valid, ld_last, ld_ready, cpu_rst, bus_err;
    logic [7:0]  ld_byte;
    logic [15:0] rd_count, wr_count;

    y86_bus_mem #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_A    (bus_A),
        .bus_RE   (bus_RE),
        .bus_WE   (bus_WE),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .ld_valid (ld_valid),
        .ld_byte  (ld_byte),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .cpu_rst  (cpu_rst),
        .bus_err  (bus_err),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [7:0]  mdl [MSIZE];
    logic [31:0] exp_q [$];
    int unsigned ld_ptr_m = 0;
    int unsigned rd_exp = 0;
    int unsigned wr_exp = 0;
    logic        err_exp = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mdl_word(input logic [31:0] addr);
        logic [31:0] w;
        for (int unsigned i = 0; i < 4; i++) begin
            w[8*i +: 8] = mdl[(32'(addr[ADDR_W-1:0]) + i) % MSIZE];
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        mdl[ld_ptr_m] = b;
        if (ld_ptr_m == MSIZE - 1) err_exp = 1'b1;
        ld_ptr_m = (ld_ptr_m + 1) % MSIZE;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] addr);
        logic in_range;
        in_range = (addr[31:ADDR_W] == '0);
        bus_A  = addr;
        bus_RE = 1'b1;
        exp_q.push_back(in_range ? mdl_word(addr) : 32'h0);
        @(negedge clk);
        check_eq(tag, bus_rdata, exp_q.pop_front());
        tick();
        bus_RE = 1'b0;
        if (in_range) rd_exp++;
        else err_exp = 1'b1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus_A     = addr;
        bus_wdata = data;
        bus_WE    = 1'b1;
        tick();
        bus_WE = 1'b0;
        if (addr[31:ADDR_W] == '0) begin
            for (int unsigned i = 0; i < 4; i++)
                mdl[(32'(addr[ADDR_W-1:0]) + i) % MSIZE] = data[8*i +: 8];
            wr_exp++;
        end else begin
            err_exp = 1'b1;
        end
    endtask

    task automatic check_counts(input string tag);
`ifdef Y86_MEM_STATS_EN
        check_eq({tag, "_rd_count"}, {16'h0, rd_count}, rd_exp);
        check_eq({tag, "_wr_count"}, {16'h0, wr_count}, wr_exp);
`else
        check_eq({tag, "_rd_count"}, {16'h0, rd_count}, 32'h0);
        check_eq({tag, "_wr_count"}, {16'h0, wr_count}, 32'h0);
`endif
    endtask

    task automatic finish_load(input string tag);
        check_eq({tag, "_release_cpu_rst"}, {31'h0, cpu_rst}, 32'h1);
        check_eq({tag, "_release_ld_ready"}, {31'h0, ld_ready}, 32'h0);
        tick();
        check_eq({tag, "_run_cpu_rst"}, {31'h0, cpu_rst}, 32'h0);
        check_eq({tag, "_run_ld_ready"}, {31'h0, ld_ready}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; bus_A = '0; bus_RE = 1'b0; bus_WE = 1'b0; bus_wdata = '0;
        ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
        tick(); tick();
        check_eq("rst_ld_ready", {31'h0, ld_ready}, 32'h1);
        check_eq("rst_cpu_rst", {31'h0, cpu_rst}, 32'h1);
        check_eq("rst_rdata", bus_rdata, 32'h0);
        check_eq("rst_bus_err", {31'h0, bus_err}, 32'h0);
        check_counts("rst");
        rst = 1'b0;

        // Zero-fill the whole array; the final byte wraps the load pointer.
        for (int unsigned i = 0; i < MSIZE; i++) load_byte(8'h00, (i == MSIZE - 1));
        check_eq("load_wrap_err", {31'h0, bus_err}, {31'h0, err_exp});

        rst = 1'b1; tick(); rst = 1'b0;
        ld_ptr_m = 0; err_exp = 1'b0; rd_exp = 0; wr_exp = 0;
        check_eq("rst2_bus_err", {31'h0, bus_err}, 32'h0);

        // Bus strobes during LOAD must be ignored.
        bus_A = 32'h0; bus_RE = 1'b1; bus_WE = 1'b1; bus_wdata = 32'hFFFF_FFFF;
        #1;
        check_eq("load_rdata_zero", bus_rdata, 32'h0);
        load_byte(8'h01, 1'b0);
        bus_RE = 1'b0; bus_WE = 1'b0;
        for (int unsigned i = 2; i <= 8; i++) load_byte(8'(i), (i == 8));
        finish_load("img");

        bus_read("rd_a0", 32'h0);
        check_eq("rd_a0_const", mdl_word(32'h0), 32'h0403_0201);
        bus_read("rd_a5", 32'h5);
        check_eq("rd_a5_const", mdl_word(32'h5), 32'h0008_0706);

        bus_write(32'h6, 32'hDEAD_BEEF);
        bus_read("rd_a6", 32'h6);
        bus_read("rd_a4", 32'h4);
        check_eq("rd_a4_const", mdl_word(32'h4), 32'hBEEF_0605);

        bus_write(32'hFFE, 32'hAABB_CCDD);
        bus_read("wrap_rd_a0", 32'h0);
        check_eq("wrap_a0_const", mdl_word(32'h0), 32'h0403_AABB);
        bus_read("wrap_rd_ffe", 32'hFFE);
        check_eq("err_clear_before_fault", {31'h0, bus_err}, 32'h0);

        bus_write(32'h0000_1000, 32'h1234_5678);
        check_eq("oob_wr_err", {31'h0, bus_err}, 32'h1);
        bus_read("oob_mem_unchanged", 32'h0);
        bus_read("oob_rd_zero", 32'h0000_1000);
        check_eq("oob_err_sticky", {31'h0, bus_err}, {31'h0, err_exp});

        // Simultaneous read+write: read sees pre-write data, write lands.
        bus_A = 32'h8; bus_wdata = 32'h1122_3344; bus_RE = 1'b1; bus_WE = 1'b1;
        exp_q.push_back(mdl_word(32'h8));
        @(negedge clk);
        check_eq("rw_pre_write", bus_rdata, exp_q.pop_front());
        tick();
        bus_RE = 1'b0; bus_WE = 1'b0;
        for (int unsigned i = 0; i < 4; i++) mdl[8 + i] = bus_wdata[8*i +: 8];
        rd_exp++; wr_exp++; err_exp = 1'b1;
        bus_read("rw_post_write", 32'h8);
        check_counts("mid");

        // Reset mid-RUN after three stores; the fourth store is cut off.
        bus_write(32'h100, 32'hCAFE_0001);
        bus_write(32'h104, 32'hCAFE_0002);
        bus_write(32'h10A, 32'hCAFE_0003);
        bus_A = 32'h200; bus_wdata = 32'h5566_7788; bus_WE = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        rd_exp = 0; wr_exp = 0; err_exp = 1'b0; ld_ptr_m = 0;
        check_eq("midrst_cpu_rst", {31'h0, cpu_rst}, 32'h1);
        check_eq("midrst_ld_ready", {31'h0, ld_ready}, 32'h1);
        check_eq("midrst_bus_err", {31'h0, bus_err}, 32'h0);
        check_counts("midrst");
        tick();
        bus_WE = 1'b0;
        rst = 1'b0;
        load_byte(mdl[0], 1'b1);
        finish_load("reload");
        bus_read("keep_100", 32'h100);
        bus_read("keep_104", 32'h104);
        bus_read("keep_10a", 32'h10A);
        bus_read("cut_200", 32'h200);
        check_eq("cut_200_const", mdl_word(32'h200), 32'h0);

        bus_read("stats_rd5", 32'h1);
        bus_write(32'h20, 32'h0BAD_F00D);
        bus_write(32'h23, 32'h7777_6666);
        bus_read("stats_after_wr", 32'h20);
        rd_exp--;  // stats window is the five reads before the two writes
        // Counters are sampled after the extra read's edge, so re-add it.
        rd_exp++;
        check_counts("stats");
`ifdef Y86_MEM_STATS_EN
        check_eq("stats_wr_const", {16'h0, wr_count}, 32'd2);
`endif
        check_eq("final_bus_err", {31'h0, bus_err}, {31'h0, err_exp});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
